tx_slot_scheduler: RTL and testbench

TX_SLOT_SCHEDULER -- requirements
Module: tx_slot_scheduler

---
 rtl/air_interface_pkg.sv | 19 +
 rtl/tdma_slot_timer.sv | 62 ++++++
 rtl/tx_slot_scheduler.sv | 196 +++++++++++++++++++
 tb/tb_tx_slot_scheduler.sv | 314 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/air_interface_pkg.sv
// Shared air-interface definitions: scheduler FSM states, default TDMA geometry and
// the slot-index width helper used by the scheduler and its slot timer.
package air_interface_pkg;

  localparam int unsigned DefSlotsPerFrame  = 8;
  localparam int unsigned DefSymbolsPerSlot = 64;

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StFire   = 2'd1,
    StActive = 2'd2
  } sched_state_e;

  // Width of a slot index; never below one bit so the ports stay legal.
  function automatic int unsigned slot_idx_w(input int unsigned slots);
    return (slots > 1) ? $clog2(slots) : 1;
  endfunction

endpackage

// File: rtl/tdma_slot_timer.sv
// TDMA timebase: counts symbol strobes within a slot, slots within a frame and frames.
// slot_start_o marks the strobe that closes a slot; next_slot_o is the slot it opens.
module tdma_slot_timer import air_interface_pkg::*; #(
  parameter int unsigned SLOTS_PER_FRAME  = DefSlotsPerFrame,
  parameter int unsigned SYMBOLS_PER_SLOT = DefSymbolsPerSlot,
  localparam int unsigned SlotW = slot_idx_w(SLOTS_PER_FRAME),
  localparam int unsigned SymW  = $clog2(SYMBOLS_PER_SLOT)
) (
  input  logic             clock_i,
  input  logic             reset_i,
  input  logic             symbol_tick_i,
  output logic             slot_start_o,
  output logic [SlotW-1:0] next_slot_o,
  output logic [SlotW-1:0] cur_slot_o,
  output logic [7:0]       frame_num_o
);

  logic [SymW-1:0]  sym_cnt_q, sym_cnt_d;
  logic [SlotW-1:0] cur_slot_q, cur_slot_d;
  logic [7:0]       frame_num_q, frame_num_d;
  logic             last_sym, last_slot;

  assign last_sym     = (sym_cnt_q == SymW'(SYMBOLS_PER_SLOT - 1));
  assign last_slot    = (cur_slot_q == SlotW'(SLOTS_PER_FRAME - 1));
  assign slot_start_o = symbol_tick_i && last_sym;
  // Slot count is a power of two, so the increment wraps on its own.
  assign next_slot_o  = cur_slot_q + SlotW'(1);
  assign cur_slot_o   = cur_slot_q;
  assign frame_num_o  = frame_num_q;

  // Advance symbol, slot and frame counters on each symbol strobe.
  always_comb begin
    sym_cnt_d   = sym_cnt_q;
    cur_slot_d  = cur_slot_q;
    frame_num_d = frame_num_q;
    if (symbol_tick_i) begin
      if (last_sym) begin
        sym_cnt_d  = '0;
        cur_slot_d = next_slot_o;
        if (last_slot) begin
          frame_num_d = frame_num_q + 8'd1;
        end
      end else begin
        sym_cnt_d = sym_cnt_q + SymW'(1);
      end
    end
  end

  // Timebase registers with synchronous reset.
  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      sym_cnt_q   <= '0;
      cur_slot_q  <= '0;
      frame_num_q <= '0;
    end else begin
      sym_cnt_q   <= sym_cnt_d;
      cur_slot_q  <= cur_slot_d;
      frame_num_q <= frame_num_d;
    end
  end

endmodule

// File: rtl/tx_slot_scheduler.sv
// TDMA transmit slot scheduler: two requesters each park one burst request for a slot;
// at the opening of that slot the scheduler fires the burst block (round-robin on a tie)
// and supervises the burst until burst_done or a one-slot timeout.
// Optional statistics counters are enabled with the TX_SCHED_STATS_EN macro.
module tx_slot_scheduler import air_interface_pkg::*; #(
  parameter int unsigned SLOTS_PER_FRAME  = DefSlotsPerFrame,
  parameter int unsigned SYMBOLS_PER_SLOT = DefSymbolsPerSlot,
  localparam int unsigned SlotW = slot_idx_w(SLOTS_PER_FRAME),
  localparam int unsigned SymW  = $clog2(SYMBOLS_PER_SLOT)
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  symbol_tick,
  input  logic                  tx_armed,
  input  logic                  burst_done,
  input  logic [1:0]            req_valid,
  input  logic [1:0][SlotW-1:0] req_slot,
  output logic [1:0]            req_ready,
  output logic                  fire_burst,
  output logic                  grant_id,
  output logic                  busy,
  output logic [SlotW-1:0]      cur_slot,
  output logic [7:0]            frame_num,
  output logic [1:0]            miss,
  output logic                  timeout
`ifdef TX_SCHED_STATS_EN
  ,
  output logic [15:0]           bursts_sent,
  output logic [15:0]           bursts_missed,
  output logic [7:0]            timeouts
`endif
);

  sched_state_e          state_q, state_d;
  logic [1:0]            pend_valid_q, pend_valid_d;
  logic [1:0][SlotW-1:0] pend_slot_q, pend_slot_d;
  logic                  grant_q, grant_d;
  logic                  rr_ptr_q, rr_ptr_d;
  logic [1:0]            miss_q, miss_d;
  logic                  timeout_q, timeout_d;
  logic [SymW-1:0]       tmo_cnt_q, tmo_cnt_d;
  logic                  slot_start;
  logic [SlotW-1:0]      next_slot;
  logic [1:0]            match;
  logic                  winner;

  tdma_slot_timer #(
    .SLOTS_PER_FRAME  (SLOTS_PER_FRAME),
    .SYMBOLS_PER_SLOT (SYMBOLS_PER_SLOT)
  ) u_timer (
    .clock_i       (clock),
    .reset_i       (reset),
    .symbol_tick_i (symbol_tick),
    .slot_start_o  (slot_start),
    .next_slot_o   (next_slot),
    .cur_slot_o    (cur_slot),
    .frame_num_o   (frame_num)
  );

  // Only registered entries compete, so a request taken on the slot_start strobe waits a frame.
  assign match[0] = slot_start && pend_valid_q[0] && (pend_slot_q[0] == next_slot);
  assign match[1] = slot_start && pend_valid_q[1] && (pend_slot_q[1] == next_slot);

  assign req_ready  = ~pend_valid_q;
  assign fire_burst = (state_q == StFire);
  assign busy       = (state_q != StIdle);
  assign grant_id   = grant_q;
  assign miss       = miss_q;
  assign timeout    = timeout_q;

  // Request capture, slot arbitration and burst supervision FSM.
  always_comb begin
    state_d      = state_q;
    pend_valid_d = pend_valid_q;
    pend_slot_d  = pend_slot_q;
    grant_d      = grant_q;
    rr_ptr_d     = rr_ptr_q;
    miss_d       = '0;
    timeout_d    = 1'b0;
    tmo_cnt_d    = tmo_cnt_q;
    winner       = 1'b0;

    for (int r = 0; r < 2; r++) begin
      if (req_valid[r] && req_ready[r]) begin
        pend_valid_d[r] = 1'b1;
        pend_slot_d[r]  = req_slot[r];
      end
    end

    if (|match) begin
      if (state_q == StIdle && tx_armed) begin
        unique case (match)
          2'b01:   winner = 1'b0;
          2'b10:   winner = 1'b1;
          default: winner = rr_ptr_q;
        endcase
        // Winner is retired now so its ready is back up during the fire cycle.
        pend_valid_d[winner] = 1'b0;
        grant_d              = winner;
        rr_ptr_d             = ~rr_ptr_q;
        tmo_cnt_d            = '0;
        state_d              = StFire;
        miss_d               = match;
        miss_d[winner]       = 1'b0;
      end else begin
        miss_d = match;
      end
    end

    unique case (state_q)
      StIdle: begin
      end
      StFire: begin
        state_d = StActive;
        if (symbol_tick) begin
          tmo_cnt_d = tmo_cnt_q + SymW'(1);
        end
      end
      StActive: begin
        if (burst_done) begin
          state_d = StIdle;
        end else if (symbol_tick) begin
          if (tmo_cnt_q == SymW'(SYMBOLS_PER_SLOT - 1)) begin
            state_d   = StIdle;
            timeout_d = 1'b1;
          end else begin
            tmo_cnt_d = tmo_cnt_q + SymW'(1);
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Scheduler state registers with synchronous reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= StIdle;
      pend_valid_q <= '0;
      pend_slot_q  <= '0;
      grant_q      <= 1'b0;
      rr_ptr_q     <= 1'b0;
      miss_q       <= '0;
      timeout_q    <= 1'b0;
      tmo_cnt_q    <= '0;
    end else begin
      state_q      <= state_d;
      pend_valid_q <= pend_valid_d;
      pend_slot_q  <= pend_slot_d;
      grant_q      <= grant_d;
      rr_ptr_q     <= rr_ptr_d;
      miss_q       <= miss_d;
      timeout_q    <= timeout_d;
      tmo_cnt_q    <= tmo_cnt_d;
    end
  end

`ifdef TX_SCHED_STATS_EN
  logic [15:0] sent_q, sent_d, missed_q, missed_d;
  logic [7:0]  tmo_tot_q, tmo_tot_d;
  logic [16:0] missed_sum;

  assign missed_sum = {1'b0, missed_q} + 17'(miss_q[0]) + 17'(miss_q[1]);

  // Saturating event counters fed by the registered pulse outputs.
  always_comb begin
    sent_d    = sent_q;
    tmo_tot_d = tmo_tot_q;
    missed_d  = missed_sum[16] ? 16'hffff : missed_sum[15:0];
    if (fire_burst && sent_q != 16'hffff) begin
      sent_d = sent_q + 16'd1;
    end
    if (timeout_q && tmo_tot_q != 8'hff) begin
      tmo_tot_d = tmo_tot_q + 8'd1;
    end
  end

  // Statistics registers, cleared by reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      sent_q    <= '0;
      missed_q  <= '0;
      tmo_tot_q <= '0;
    end else begin
      sent_q    <= sent_d;
      missed_q  <= missed_d;
      tmo_tot_q <= tmo_tot_d;
    end
  end

  assign bursts_sent   = sent_q;
  assign bursts_missed = missed_q;
  assign timeouts      = tmo_tot_q;
`endif

endmodule

// File: tb/tb_tx_slot_scheduler.sv
// Directed bench for tx_slot_scheduler: a default-geometry instance for scheduling
// scenarios and a 2-slot/2-symbol instance for the frame counter wrap.
module tb_tx_slot_scheduler;

  logic            clock = 1'b0;
  logic            reset = 1'b1;
  logic            symbol_tick = 1'b0;
  logic            tx_armed = 1'b0;
  logic            burst_done = 1'b0;
  logic [1:0]      req_valid = '0;
  logic [1:0][2:0] req_slot = '0;
  logic [1:0]      req_ready;
  logic            fire_burst, grant_id, busy, timeout;
  logic [2:0]      cur_slot;
  logic [7:0]      frame_num;
  logic [1:0]      miss;

  logic [1:0][0:0] w_req_slot = '0;
  logic [1:0]      w_req_ready, w_miss;
  logic            w_fire, w_grant, w_busy, w_timeout;
  logic [0:0]      w_cur_slot;
  logic [7:0]      w_frame;

`ifdef TX_SCHED_STATS_EN
  logic [15:0] bursts_sent, bursts_missed, w_sent, w_missed;
  logic [7:0]  timeouts, w_tmos;
`endif

  int errors = 0;
  int checks = 0;
  int fire_cnt = 0;
  int f0;

  tx_slot_scheduler dut (
    .clock       (clock),
    .reset       (reset),
    .symbol_tick (symbol_tick),
    .tx_armed    (tx_armed),
    .burst_done  (burst_done),
    .req_valid   (req_valid),
    .req_slot    (req_slot),
    .req_ready   (req_ready),
    .fire_burst  (fire_burst),
    .grant_id    (grant_id),
    .busy        (busy),
    .cur_slot    (cur_slot),
    .frame_num   (frame_num),
    .miss        (miss),
`ifdef TX_SCHED_STATS_EN
    .bursts_sent   (bursts_sent),
    .bursts_missed (bursts_missed),
    .timeouts      (timeouts),
`endif
    .timeout     (timeout)
  );

  tx_slot_scheduler #(
    .SLOTS_PER_FRAME  (2),
    .SYMBOLS_PER_SLOT (2)
  ) dut_w (
    .clock       (clock),
    .reset       (reset),
    .symbol_tick (symbol_tick),
    .tx_armed    (1'b0),
    .burst_done  (1'b0),
    .req_valid   (2'b00),
    .req_slot    (w_req_slot),
    .req_ready   (w_req_ready),
    .fire_burst  (w_fire),
    .grant_id    (w_grant),
    .busy        (w_busy),
    .cur_slot    (w_cur_slot),
    .frame_num   (w_frame),
    .miss        (w_miss),
`ifdef TX_SCHED_STATS_EN
    .bursts_sent   (w_sent),
    .bursts_missed (w_missed),
    .timeouts      (w_tmos),
`endif
    .timeout     (w_timeout)
  );

  always #5 clock = ~clock;

  // Count fire pulses away from the active edge.
  always @(negedge clock) if (fire_burst) fire_cnt++;

  task automatic cycle();
    @(posedge clock);
    #1;
  endtask

  task automatic ticks(input int n);
    symbol_tick = 1'b1;
    repeat (n) cycle();
    symbol_tick = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1; req_valid = '0; burst_done = 1'b0; symbol_tick = 1'b0; tx_armed = 1'b1;
    cycle(); cycle();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; tx_armed = 1'b1;
    cycle(); cycle();
    checks++; if (fire_burst !== 1'b0) begin errors++; $display("FAIL rst_fire got %b want 0", fire_burst); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy got %b want 0", busy); end
    checks++; if (grant_id !== 1'b0) begin errors++; $display("FAIL rst_grant got %b want 0", grant_id); end
    checks++; if (miss !== 2'b00) begin errors++; $display("FAIL rst_miss got %b want 00", miss); end
    checks++; if (timeout !== 1'b0) begin errors++; $display("FAIL rst_timeout got %b want 0", timeout); end
    checks++; if (cur_slot !== 3'd0) begin errors++; $display("FAIL rst_slot got %0d want 0", cur_slot); end
    checks++; if (frame_num !== 8'd0) begin errors++; $display("FAIL rst_frame got %0d want 0", frame_num); end
    checks++; if (req_ready !== 2'b11) begin errors++; $display("FAIL rst_ready got %b want 11", req_ready); end
    reset = 1'b0; burst_done = 1'b1;
    cycle();
    burst_done = 1'b0;
    checks++; if (busy !== 1'b0 || timeout !== 1'b0) begin
      errors++; $display("FAIL idle_done got busy=%b tmo=%b want 0 0", busy, timeout);
    end
    ticks(63);
    checks++; if (cur_slot !== 3'd0) begin errors++; $display("FAIL sym63_slot got %0d want 0", cur_slot); end
    ticks(1);
    checks++; if (cur_slot !== 3'd1) begin errors++; $display("FAIL sym64_slot got %0d want 1", cur_slot); end
  endtask

  task automatic test_single_fire();
    do_reset();
    req_valid = 2'b01; req_slot[0] = 3'd3;
    cycle();
    req_valid = 2'b00;
    checks++; if (req_ready !== 2'b10) begin errors++; $display("FAIL sf_ready_taken got %b want 10", req_ready); end
    f0 = fire_cnt;
    ticks(191);
    checks++; if (cur_slot !== 3'd2 || fire_cnt != f0) begin
      errors++; $display("FAIL sf_pre got slot=%0d fires=%0d want 2 %0d", cur_slot, fire_cnt, f0);
    end
    ticks(1);
    checks++; if (fire_burst !== 1'b1) begin errors++; $display("FAIL sf_fire got %b want 1", fire_burst); end
    checks++; if (grant_id !== 1'b0 || busy !== 1'b1) begin
      errors++; $display("FAIL sf_grant got g=%b busy=%b want 0 1", grant_id, busy);
    end
    checks++; if (req_ready !== 2'b11) begin errors++; $display("FAIL sf_ready got %b want 11", req_ready); end
    checks++; if (cur_slot !== 3'd3) begin errors++; $display("FAIL sf_slot got %0d want 3", cur_slot); end
    cycle();
    checks++; if (fire_burst !== 1'b0 || busy !== 1'b1) begin
      errors++; $display("FAIL sf_active got fire=%b busy=%b want 0 1", fire_burst, busy);
    end
    burst_done = 1'b1;
    cycle();
    burst_done = 1'b0;
    checks++; if (busy !== 1'b0 || fire_cnt != f0 + 1) begin
      errors++; $display("FAIL sf_done got busy=%b fires=%0d want 0 %0d", busy, fire_cnt, f0 + 1);
    end
  endtask

  task automatic test_round_robin();
    do_reset();
    req_valid = 2'b11; req_slot[0] = 3'd5; req_slot[1] = 3'd5;
    cycle();
    req_valid = 2'b00;
    ticks(319);
    ticks(1);
    checks++; if (fire_burst !== 1'b1 || grant_id !== 1'b0) begin
      errors++; $display("FAIL rr_n got fire=%b g=%b want 1 0", fire_burst, grant_id);
    end
    checks++; if (miss !== 2'b10) begin errors++; $display("FAIL rr_miss got %b want 10", miss); end
    checks++; if (req_ready !== 2'b01) begin errors++; $display("FAIL rr_ready got %b want 01", req_ready); end
    burst_done = 1'b1;
    cycle();
    burst_done = 1'b0;
    ticks(511);
    ticks(1);
    checks++; if (fire_burst !== 1'b1 || grant_id !== 1'b1) begin
      errors++; $display("FAIL rr_n1 got fire=%b g=%b want 1 1", fire_burst, grant_id);
    end
    checks++; if (miss !== 2'b00 || frame_num !== 8'd1) begin
      errors++; $display("FAIL rr_n1_misc got miss=%b frame=%0d want 00 1", miss, frame_num);
    end
    burst_done = 1'b1;
    cycle();
    burst_done = 1'b0;
  endtask

  task automatic test_unarmed();
    do_reset();
    tx_armed = 1'b0;
    req_valid = 2'b10; req_slot[1] = 3'd1;
    cycle();
    req_valid = 2'b00;
    f0 = fire_cnt;
    ticks(63);
    ticks(1);
    checks++; if (miss !== 2'b10) begin errors++; $display("FAIL ua_miss got %b want 10", miss); end
    checks++; if (fire_burst !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL ua_nofire got fire=%b busy=%b want 0 0", fire_burst, busy);
    end
    checks++; if (req_ready !== 2'b01) begin errors++; $display("FAIL ua_pending got %b want 01", req_ready); end
    cycle();
    checks++; if (miss !== 2'b00) begin errors++; $display("FAIL ua_miss_pulse got %b want 00", miss); end
    tx_armed = 1'b1;
    ticks(511);
    ticks(1);
    checks++; if (fire_burst !== 1'b1 || grant_id !== 1'b1) begin
      errors++; $display("FAIL ua_fire got fire=%b g=%b want 1 1", fire_burst, grant_id);
    end
    burst_done = 1'b1;
    cycle();
    burst_done = 1'b0;
    checks++; if (fire_cnt != f0 + 1) begin
      errors++; $display("FAIL ua_count got %0d want %0d", fire_cnt, f0 + 1);
    end
  endtask

  task automatic test_timeout();
    do_reset();
    req_valid = 2'b01; req_slot[0] = 3'd1;
    cycle();
    req_valid = 2'b00;
    ticks(63);
    ticks(1);
    checks++; if (fire_burst !== 1'b1) begin errors++; $display("FAIL to_fire got %b want 1", fire_burst); end
    cycle();
    ticks(63);
    checks++; if (busy !== 1'b1 || timeout !== 1'b0) begin
      errors++; $display("FAIL to_early got busy=%b tmo=%b want 1 0", busy, timeout);
    end
    ticks(1);
    checks++; if (timeout !== 1'b1 || busy !== 1'b0) begin
      errors++; $display("FAIL to_pulse got tmo=%b busy=%b want 1 0", timeout, busy);
    end
    cycle();
    checks++; if (timeout !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL to_after got tmo=%b busy=%b want 0 0", timeout, busy);
    end
  endtask

  task automatic test_late_request();
    do_reset();
    ticks(255);
    checks++; if (cur_slot !== 3'd3) begin errors++; $display("FAIL lr_pre got %0d want 3", cur_slot); end
    req_valid = 2'b01; req_slot[0] = 3'd4; symbol_tick = 1'b1;
    cycle();
    req_valid = 2'b00; symbol_tick = 1'b0;
    checks++; if (fire_burst !== 1'b0 || cur_slot !== 3'd4) begin
      errors++; $display("FAIL lr_same got fire=%b slot=%0d want 0 4", fire_burst, cur_slot);
    end
    checks++; if (req_ready !== 2'b10) begin errors++; $display("FAIL lr_ready got %b want 10", req_ready); end
    f0 = fire_cnt;
    ticks(511);
    checks++; if (fire_cnt != f0) begin errors++; $display("FAIL lr_early got %0d want %0d", fire_cnt, f0); end
    ticks(1);
    checks++; if (fire_burst !== 1'b1 || cur_slot !== 3'd4) begin
      errors++; $display("FAIL lr_fire got fire=%b slot=%0d want 1 4", fire_burst, cur_slot);
    end
    burst_done = 1'b1;
    cycle();
    burst_done = 1'b0;
  endtask

  task automatic test_reset_mid_burst();
    do_reset();
    req_valid = 2'b11; req_slot[1] = 3'd1; req_slot[0] = 3'd6;
    cycle();
    req_valid = 2'b00;
    ticks(63);
    ticks(1);
    cycle();
    checks++; if (busy !== 1'b1 || grant_id !== 1'b1) begin
      errors++; $display("FAIL rm_active got busy=%b g=%b want 1 1", busy, grant_id);
    end
    reset = 1'b1;
    cycle();
    checks++; if (busy !== 1'b0 || grant_id !== 1'b0 || fire_burst !== 1'b0) begin
      errors++; $display("FAIL rm_outs got busy=%b g=%b fire=%b want 0 0 0", busy, grant_id, fire_burst);
    end
    checks++; if (cur_slot !== 3'd0 || req_ready !== 2'b11) begin
      errors++; $display("FAIL rm_state got slot=%0d ready=%b want 0 11", cur_slot, req_ready);
    end
    reset = 1'b0; burst_done = 1'b1;
    cycle();
    burst_done = 1'b0;
    checks++; if (busy !== 1'b0 || timeout !== 1'b0 || fire_burst !== 1'b0) begin
      errors++; $display("FAIL rm_done got busy=%b tmo=%b fire=%b want 0 0 0", busy, timeout, fire_burst);
    end
  endtask

  task automatic test_frame_wrap();
    do_reset();
    ticks(1020);
    checks++; if (w_frame !== 8'd255 || w_cur_slot !== 1'b0) begin
      errors++; $display("FAIL fw_255 got frame=%0d slot=%0d want 255 0", w_frame, w_cur_slot);
    end
    ticks(3);
    checks++; if (w_frame !== 8'd255) begin errors++; $display("FAIL fw_hold got %0d want 255", w_frame); end
    ticks(1);
    checks++; if (w_frame !== 8'd0) begin errors++; $display("FAIL fw_wrap got %0d want 0", w_frame); end
  endtask

  initial begin
    test_reset();
    test_single_fire();
    test_round_robin();
    test_unarmed();
    test_timeout();
    test_late_request();
    test_reset_mid_burst();
    test_frame_wrap();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
